audio_rx_deserializer: RTL and testbench

- Upstream front-end for the effect chain.
- Receives the codec ADC serial stream in left-justified format (bclk, lrclk, adcdat), oversampled in the system clock domain, and assembles one stereo frame per lrclk period.
- Presents parallel samples plus a one-cycle audio_ready strobe directly to the x / audio_ready inputs of the distortion stage.

---
 rtl/audio_rx_deserializer.sv | 193 +++++++++++++++++++
 tb/tb_audio_rx_deserializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/audio_rx_deserializer.sv
// Left-justified codec ADC receiver: oversamples bclk/lrclk/adcdat in the CLK domain and
// publishes one stereo frame per lrclk period with a single-cycle audio_ready strobe.
module audio_rx_deserializer #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  bclk,
  input  logic                  lrclk,
  input  logic                  adcdat,
  output logic [DATA_WIDTH-1:0] sample_l,
  output logic [DATA_WIDTH-1:0] sample_r,
  output logic                  audio_ready,
  output logic                  frame_err
);

  localparam int             CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT_L = 3'd1,
    WAIT_R  = 3'd2,
    SHIFT_R = 3'd3,
    WAIT_L  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrclk_sync;
  logic [SYNC_STAGES-1:0] adcdat_sync;
  logic                   bclk_prev;
  logic                   lrclk_prev;

  logic bclk_s;
  logic lrclk_s;
  logic adcdat_s;
  logic bclk_rise;
  logic lr_rise;
  logic lr_fall;
  logic lr_edge;

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [DATA_WIDTH-1:0] shift_l;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  shift_l_en;
  logic                  shift_r_en;
  logic                  pub;
  logic                  pub_q;
  logic                  err;

  // Input synchronizers plus one edge-detect register for the clock-like inputs
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      bclk_sync   <= '0;
      lrclk_sync  <= '0;
      adcdat_sync <= '0;
      bclk_prev   <= 1'b0;
      lrclk_prev  <= 1'b0;
    end else begin
      bclk_sync   <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lrclk_sync  <= {lrclk_sync[SYNC_STAGES-2:0], lrclk};
      adcdat_sync <= {adcdat_sync[SYNC_STAGES-2:0], adcdat};
      bclk_prev   <= bclk_sync[SYNC_STAGES-1];
      lrclk_prev  <= lrclk_sync[SYNC_STAGES-1];
    end
  end

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign lrclk_s   = lrclk_sync[SYNC_STAGES-1];
  assign adcdat_s  = adcdat_sync[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev;
  assign lr_rise   = lrclk_s & ~lrclk_prev;
  assign lr_fall   = ~lrclk_s & lrclk_prev;
  assign lr_edge   = lr_rise | lr_fall;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // lrclk edges win over a coincident bclk rise; that bit opens the new slot
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, WAIT_L: begin
          if (lr_rise) state_nxt = SHIFT_L;
        end
        SHIFT_L: begin
          if (lr_edge) state_nxt = IDLE;
          else if (bclk_rise && cnt == LAST_BIT) state_nxt = WAIT_R;
        end
        WAIT_R: begin
          if (lr_fall) state_nxt = SHIFT_R;
        end
        SHIFT_R: begin
          if (lr_edge) state_nxt = IDLE;
          else if (bclk_rise && cnt == LAST_BIT) state_nxt = WAIT_L;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_nxt    = cnt;
    shift_l_en = 1'b0;
    shift_r_en = 1'b0;
    pub        = 1'b0;
    err        = 1'b0;
    if (!en) begin
      cnt_nxt = '0;
    end else begin
      case (state)
        IDLE, WAIT_L: begin
          if (lr_rise) begin
            shift_l_en = bclk_rise;
            cnt_nxt    = bclk_rise ? CW'(1) : '0;
          end
        end
        SHIFT_L: begin
          if (lr_edge) begin
            err     = 1'b1;
            cnt_nxt = '0;
          end else if (bclk_rise) begin
            shift_l_en = 1'b1;
            cnt_nxt    = cnt + CW'(1);
          end
        end
        WAIT_R: begin
          if (lr_fall) begin
            shift_r_en = bclk_rise;
            cnt_nxt    = bclk_rise ? CW'(1) : '0;
          end
        end
        SHIFT_R: begin
          if (lr_edge) begin
            err     = 1'b1;
            cnt_nxt = '0;
          end else if (bclk_rise) begin
            shift_r_en = 1'b1;
            cnt_nxt    = cnt + CW'(1);
            pub        = (cnt == LAST_BIT);
          end
        end
        default: cnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      shift_l <= '0;
      shift_r <= '0;
      pub_q   <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      pub_q <= pub;
      if (shift_l_en) shift_l <= {shift_l[DATA_WIDTH-2:0], adcdat_s};
      if (shift_r_en) shift_r <= {shift_r[DATA_WIDTH-2:0], adcdat_s};
    end
  end

  // Publish one cycle after the final right bit lands in shift_r
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      sample_l    <= '0;
      sample_r    <= '0;
      audio_ready <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      audio_ready <= pub_q & en;
      frame_err   <= err;
      if (pub_q && en) begin
        sample_l <= shift_l;
        sample_r <= shift_r;
      end
    end
  end

endmodule

// File: tb/tb_audio_rx_deserializer.sv
// Directed bench for audio_rx_deserializer: drives left-justified frames at bclk = CLK/4.
module tb_audio_rx_deserializer;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        bclk = 1'b0;
  logic        lrclk = 1'b0;
  logic        adcdat = 1'b0;
  logic [31:0] sample_l;
  logic [31:0] sample_r;
  logic        audio_ready;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;
  int ready_cnt = 0;
  int ready_cyc = 0;
  int ready_wide = 0;
  int err_high = 0;
  int err_pulses = 0;
  logic prev_ready = 1'b0;
  logic prev_err = 1'b0;

  audio_rx_deserializer #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .rst(rst), .en(en), .bclk(bclk), .lrclk(lrclk), .adcdat(adcdat),
    .sample_l(sample_l), .sample_r(sample_r), .audio_ready(audio_ready), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (audio_ready) begin
      ready_cnt <= ready_cnt + 1;
      ready_cyc <= cyc;
      if (prev_ready) ready_wide <= ready_wide + 1;
    end
    if (frame_err) begin
      err_high <= err_high + 1;
      if (!prev_err) err_pulses <= err_pulses + 1;
    end
    prev_ready <= audio_ready;
    prev_err   <= frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One bclk period per bit: lrclk/data change with bclk low, rise after 2 CLK
  task automatic send_bits(input logic [31:0] d, input int n, input logic lr);
    for (int i = 0; i < n; i++) begin
      bclk   = 1'b0;
      lrclk  = lr;
      adcdat = (i < 32) ? d[31-i] : 1'($urandom);
      idle(2);
      bclk      = 1'b1;
      last_rise = cyc;
      idle(2);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_bits(l, n, 1'b1);
    send_bits(r, n, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    idle(3);
    check("reset_sample_l", sample_l, 32'h0);
    check("reset_sample_r", sample_r, 32'h0);
    check("reset_audio_ready", {31'b0, audio_ready}, 32'h0);
    check("reset_frame_err", {31'b0, frame_err}, 32'h0);
    rst = 1'b1;
    en  = 1'b1;
    idle(4);

    // stream joins mid right slot
    send_bits(32'hFFFF0000, 12, 1'b0);
    idle(8);
    check("midstart_no_ready", ready_cnt, 0);
    check("midstart_sample_l", sample_l, 32'h0);

    send_frame(32'h12345678, 32'h89ABCDEF, 32);
    idle(8);
    check("f1_sample_l", sample_l, 32'h12345678);
    check("f1_sample_r", sample_r, 32'h89ABCDEF);
    check("f1_ready_cnt", ready_cnt, 1);
    check("f1_latency", ready_cyc - last_rise, 4);

    send_frame(32'h12345678, 32'h89ABCDEF, 32);
    idle(8);
    check("f2_ready_cnt", ready_cnt, 2);
    check("f2_latency", ready_cyc - last_rise, 4);
    check("f2_ready_width", ready_wide, 0);

    // 48-bit slots, trailing bits random
    send_frame(32'hA5A5A5A5, 32'h0000FFFF, 48);
    idle(8);
    check("long_sample_l", sample_l, 32'hA5A5A5A5);
    check("long_sample_r", sample_r, 32'h0000FFFF);
    check("long_ready_cnt", ready_cnt, 3);
    check("long_no_err", err_pulses, 0);

    // left slot cut short after 20 bits
    send_bits(32'h11111111, 20, 1'b1);
    send_bits(32'h22222222, 32, 1'b0);
    idle(8);
    check("short_err_pulses", err_pulses, 1);
    check("short_err_width", err_high, 1);
    check("short_no_ready", ready_cnt, 3);
    check("short_hold_l", sample_l, 32'hA5A5A5A5);
    check("short_hold_r", sample_r, 32'h0000FFFF);

    send_frame(32'hDEADBEEF, 32'h00000001, 32);
    idle(8);
    check("recover_sample_l", sample_l, 32'hDEADBEEF);
    check("recover_sample_r", sample_r, 32'h00000001);
    check("recover_ready_cnt", ready_cnt, 4);
    check("recover_err_pulses", err_pulses, 1);

    // enable dropped mid-left, restored mid-right
    send_bits(32'hCAFEF00D, 10, 1'b1);
    en = 1'b0;
    send_bits(32'h3C3C3C3C, 22, 1'b1);
    send_bits(32'h0BADC0DE, 10, 1'b0);
    en = 1'b1;
    send_bits(32'h5A5A5A5A, 22, 1'b0);
    idle(8);
    check("en_no_ready", ready_cnt, 4);
    check("en_hold_l", sample_l, 32'hDEADBEEF);
    check("en_hold_r", sample_r, 32'h00000001);
    check("en_no_err", err_pulses, 1);

    send_frame(32'h55AA33CC, 32'h0F0F0F0F, 32);
    idle(8);
    check("en_resume_l", sample_l, 32'h55AA33CC);
    check("en_resume_r", sample_r, 32'h0F0F0F0F);
    check("en_resume_ready_cnt", ready_cnt, 5);

    // reset pulse during the right slot
    send_bits(32'h13579BDF, 32, 1'b1);
    send_bits(32'h2468ACE0, 12, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_sample_l", sample_l, 32'h0);
    check("midrst_sample_r", sample_r, 32'h0);
    check("midrst_audio_ready", {31'b0, audio_ready}, 32'h0);
    idle(2);
    rst = 1'b1;
    send_bits(32'h8ACE0000, 20, 1'b0);
    idle(8);
    check("postrst_no_ready", ready_cnt, 5);
    check("postrst_hold_l", sample_l, 32'h0);

    send_frame(32'h7E57DA7A, 32'hC0FFEE00, 32);
    idle(8);
    check("postrst_sample_l", sample_l, 32'h7E57DA7A);
    check("postrst_sample_r", sample_r, 32'hC0FFEE00);
    check("postrst_ready_cnt", ready_cnt, 6);
    check("postrst_latency", ready_cyc - last_rise, 4);
    check("final_ready_width", ready_wide, 0);
    check("final_err_pulses", err_pulses, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
